load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory interface: accepts one load/store request at a time from the
//  processor datapath, converts byte addresses to word indices, and drives the data memory's
//  read/write port (word-addressed, combinational read, write on posedge clk).
//  Supports byte/half/word loads (zero- or sign-extended) and stores; sub-word stores use read-modify-write.
// PARAMETERS
//  DEPTH_WORDS   128  number of 32-bit words in the data memory; valid word index 0..DEPTH_WORDS-1
//  BIG_ENDIAN    1    1: byte offset 0 = bits[31:24]; 0: byte offset 0 = bits[7:0]
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  req_valid      in   1   request present
//  req_ready      out  1   unit can accept a request (high only in IDLE)
//  req_write      in   1   1 = store, 0 = load
//  req_size       in   2   0 = byte, 1 = half, 2 = word, 3 = illegal
//  req_signed     in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid     out  1   one-cycle pulse: request complete
//  resp_rdata     out  32  load result, extended to 32 bits; 0 for stores and errors
//  resp_err       out  1   valid with resp_valid: misaligned, out of range, or size==3
//  mem_read_en    out  1   drives memory MemRead
//  mem_read_addr  out  32  word index (req_addr>>2)
//  mem_read_data  in   32  memory readData (combinational from mem_read_addr)
//  mem_write_en   out  1   drives memory MemWrite; forced 0 whenever rst is high
//  mem_write_addr out  32  word index
//  mem_write_data out  32  full merged word
// BEHAVIOUR
//  - States: IDLE, READ, WRITE, RESP. Request captured (addr, size, signed, wdata, write) on IDLE&req_valid.
//  - Reset: state=IDLE; req_ready, resp_valid, resp_err, mem_read_en, mem_write_en = 0; resp_rdata and
//    all address/data outputs = 0. req_ready rises the first cycle after rst deasserts.
//  - Accept at edge T (IDLE, req_valid&req_ready). Check at accept: size==3, half with addr[0]!=0,
//    word with addr[1:0]!=0, or (addr>>2)>=DEPTH_WORDS -> error; next state RESP, no memory strobes.
//  - Load: IDLE->READ->RESP. READ: mem_read_en=1, word captured at end of READ; lane select per
//    addr[1:0] and BIG_ENDIAN, then extend. resp_valid during cycle T+2.
//  - Store word: IDLE->WRITE->RESP. WRITE: mem_write_en=1 for exactly one cycle, data=req_wdata.
//  - Store byte/half: IDLE->READ->WRITE->RESP. READ captures old word; WRITE writes old word with only
//    the addressed lane(s) replaced. resp_valid during cycle T+3. Other bytes must be unchanged.
//  - RESP: resp_valid=1 for one cycle, then IDLE; resp_rdata/resp_err hold until next RESP.
//  - mem_read_en and mem_write_en are never high in the same cycle; no strobes in IDLE or RESP.
//  - mem_*_addr hold the captured word index from accept until next accept.
//  - req_valid in non-IDLE states is ignored (not queued); requester must hold it until req_ready.
//  - Reset mid-operation: pending request dropped, no resp_valid, no write commits (mem_write_en gated).
//  - Highest word index DEPTH_WORDS-1 legal; DEPTH_WORDS is an error. No address wrap-around.
// TESTING
//  - Store word 0xDEADBEEF @ addr 0x8, load word @0x8 -> one write strobe, resp_rdata=0xDEADBEEF, lat 2.
//  - After above, store byte 0x11 @0x9 (BE) -> word2=0xDE11BEEF; lbz @0x9 -> 0x11; lat 3 for store.
//  - Word2=0xDE11BEEF: lha @0x8 signed -> 0xFFFFDE11; lhz @0xA -> 0x0000BEEF.
//  - Load word @0x6, half @0x3, size=3, word @0x200 (idx 128) -> resp_err=1, rdata=0, no strobes.
//  - Assert rst during WRITE of a sub-word store -> mem_write_en=0, memory unchanged, no resp_valid,
//    req_ready=1 one cycle after rst drops.
//  - Back-to-back: req_valid held high for 3 requests -> each accepted only in IDLE, responses in order.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the data-memory interface. Accepts one load/store at a time, turns the byte
//   address into a word index and drives a word-addressed memory with a combinational read port
//   and a write port that commits on posedge clk. Byte/half stores are read-modify-write.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   req_valid / req_ready       request handshake (ready only while idle)
//   req_write, req_size,        store flag, size (0 byte, 1 half, 2 word, 3 illegal),
//   req_signed, req_addr,       sign-extend flag for loads, byte address,
//   req_wdata                   right-justified store data
//   resp_valid                  one-cycle completion pulse
//   resp_rdata, resp_err        extended load result (0 for stores/errors), error flag
//   mem_read_en/addr/data       memory read port (word index)
//   mem_write_en/addr/data      memory write port (word index, full merged word)

module load_store_unit #(
   parameter int unsigned DEPTH_WORDS = 128,
   parameter bit          BIG_ENDIAN  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read_en,
   output logic [31:0] mem_read_addr,
   input  logic [31:0] mem_read_data,
   output logic        mem_write_en,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_data
);

   localparam logic [1:0]  SizeByte   = 2'd0;
   localparam logic [1:0]  SizeHalf   = 2'd1;
   localparam logic [1:0]  SizeWord   = 2'd2;
   localparam logic [29:0] DepthLimit = 30'(DEPTH_WORDS);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

   state_e      state_q, state_d;
   logic [1:0]  size_q;
   logic        signed_q;
   logic        write_q;
   logic [1:0]  offset_q;
   logic [31:0] idx_q;
   logic [31:0] wr_data_q;   // store data at accept, merged word after the read of an RMW
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;

   logic        accept;
   logic        req_err;
   logic [4:0]  shamt;
   logic [31:0] lane;
   logic [31:0] lane_mask;
   logic [31:0] load_data;
   logic [31:0] merged;

   assign req_ready = (state_q == StIdle) && !rst;
   assign accept    = req_ready && req_valid;

   // No wrap-around: any word index at or beyond the memory depth is an error.
   assign req_err = (req_size == 2'd3)
                 || ((req_size == SizeHalf) && req_addr[0])
                 || ((req_size == SizeWord) && (req_addr[1:0] != 2'b00))
                 || (req_addr[31:2] >= DepthLimit);

   // Bit position of the addressed lane inside the 32-bit word.
   always_comb begin
      shamt = 5'd0;
      if (size_q != SizeWord) begin
         if (BIG_ENDIAN) begin
            if (size_q == SizeByte) shamt = {2'(2'd3 - offset_q), 3'b000};
            else                    shamt = {2'(2'd2 - offset_q), 3'b000};
         end else begin
            shamt = {offset_q, 3'b000};
         end
      end
   end

   assign lane      = mem_read_data >> shamt;
   assign lane_mask = ((size_q == SizeByte) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
   assign merged    = (mem_read_data & ~lane_mask) | ((wr_data_q << shamt) & lane_mask);

   always_comb begin
      load_data = mem_read_data;
      unique case (size_q)
         SizeByte: load_data = {{24{signed_q & lane[7]}}, lane[7:0]};
         SizeHalf: load_data = {{16{signed_q & lane[15]}}, lane[15:0]};
         default:  load_data = mem_read_data;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_err)                    state_d = StResp;
               else if (!req_write)            state_d = StRead;
               else if (req_size == SizeWord)  state_d = StWrite;
               else                            state_d = StRead;
            end
         end
         StRead:  state_d = write_q ? StWrite : StResp;
         StWrite: state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         size_q       <= 2'd0;
         signed_q     <= 1'b0;
         write_q      <= 1'b0;
         offset_q     <= 2'd0;
         idx_q        <= 32'd0;
         wr_data_q    <= 32'd0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  size_q    <= req_size;
                  signed_q  <= req_signed;
                  write_q   <= req_write;
                  offset_q  <= req_addr[1:0];
                  idx_q     <= {2'b00, req_addr[31:2]};
                  wr_data_q <= req_wdata;
                  if (req_err) begin
                     resp_rdata_q <= 32'd0;
                     resp_err_q   <= 1'b1;
                  end
               end
            end
            StRead: begin
               if (write_q) begin
                  wr_data_q <= merged;
               end else begin
                  resp_rdata_q <= load_data;
                  resp_err_q   <= 1'b0;
               end
            end
            StWrite: begin
               resp_rdata_q <= 32'd0;
               resp_err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Strobes are gated by rst so an in-flight write never commits during reset.
   assign mem_read_en    = (state_q == StRead) && !rst;
   assign mem_write_en   = (state_q == StWrite) && !rst;
   assign mem_read_addr  = idx_q;
   assign mem_write_addr = idx_q;
   assign mem_write_data = wr_data_q;
   assign resp_valid     = (state_q == StResp) && !rst;
   assign resp_rdata     = resp_rdata_q;
   assign resp_err       = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Scoreboard bench for load_store_unit: the driver pushes the hand-computed response of each
//   request into a queue, and a negedge monitor pops and compares data, error, latency and the
//   number of read/write strobes seen while the request was in flight.

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read_en;
   logic [31:0] mem_read_addr;
   logic [31:0] mem_read_data;
   logic        mem_write_en;
   logic [31:0] mem_write_addr;
   logic [31:0] mem_write_data;

   load_store_unit #(
      .DEPTH_WORDS(128),
      .BIG_ENDIAN (1'b1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_size      (req_size),
      .req_signed    (req_signed),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_err      (resp_err),
      .mem_read_en   (mem_read_en),
      .mem_read_addr (mem_read_addr),
      .mem_read_data (mem_read_data),
      .mem_write_en  (mem_write_en),
      .mem_write_addr(mem_write_addr),
      .mem_write_data(mem_write_data)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on posedge.
   logic [31:0] mem [128];
   logic        mem_clr;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
      end else if (mem_write_en) begin
         mem[mem_write_addr[6:0]] <= mem_write_data;
      end
   end

   assign mem_read_data = (mem_read_addr < 32'd128) ? mem[mem_read_addr[6:0]] : 32'hBAD0_BAD0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          reads;
      int          writes;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   cyc = 0;
   int   rd_cnt = 0;
   int   wr_cnt = 0;
   int   asserts = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: inputs are driven 1 time unit after posedge, so negedge sees a stable cycle.
   always @(negedge clk) begin
      if (rst) begin
         acc_q.delete();
         rd_cnt = 0;
         wr_cnt = 0;
      end else begin
         chk("strobe_overlap", 32'(mem_read_en && mem_write_en), 32'd0);
         if (mem_read_en)  rd_cnt++;
         if (mem_write_en) wr_cnt++;
         if (resp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               asserts++;
               failures++;
               $display("FAIL unexpected_resp: got resp_valid=1, expected no response");
            end else begin
               exp_t e;
               int   a;
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_err", 32'(resp_err), 32'(e.err));
               chk("latency", 32'(cyc - a), 32'(e.lat));
               chk("read_strobes", 32'(rd_cnt), 32'(e.reads));
               chk("write_strobes", 32'(wr_cnt), 32'(e.writes));
            end
         end
         if (req_valid && req_ready) begin
            acc_q.push_back(cyc);
            rd_cnt = 0;
            wr_cnt = 0;
         end
      end
   end

   // Drives a request and returns 1 time unit after the accepting edge; req_valid stays high.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat,
                        input int nr, input int nw, input bit push);
      bit ok = 1'b0;
      if (push) begin
         exp_t e;
         e.rdata = er; e.err = ee; e.lat = lat; e.reads = nr; e.writes = nw;
         exp_q.push_back(e);
      end
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         asserts++;
         failures++;
         $display("FAIL accept_timeout: got req_ready=0 for 50 cycles, expected 1");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      req_valid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         asserts++;
         failures++;
         $display("FAIL resp_timeout: got %0d pending responses, expected 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      mem_clr    = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_read_en", 32'(mem_read_en), 32'd0);
      chk("rst_mem_write_en", 32'(mem_write_en), 32'd0);
      chk("rst_mem_write_data", mem_write_data, 32'd0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      mem_clr = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;

      // Word store then load; sub-word RMW and big-endian lane selection on word 2.
      issue(1, 2, 0, 32'h8, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 1, 1);
      issue(0, 2, 0, 32'h8, 32'h0, 32'hDEAD_BEEF, 0, 2, 1, 0, 1);
      issue(1, 0, 0, 32'h9, 32'h0000_0011, 32'h0, 0, 3, 1, 1, 1);
      drain();
      chk("mem2_after_sb", mem[2], 32'hDE11_BEEF);
      issue(0, 0, 0, 32'h9, 32'h0, 32'h0000_0011, 0, 2, 1, 0, 1);
      issue(0, 1, 1, 32'h8, 32'h0, 32'hFFFF_DE11, 0, 2, 1, 0, 1);
      issue(0, 1, 0, 32'hA, 32'h0, 32'h0000_BEEF, 0, 2, 1, 0, 1);

      // Errors: misaligned word, misaligned half, illegal size, index == depth.
      issue(0, 2, 0, 32'h6, 32'h0, 32'h0, 1, 1, 0, 0, 1);
      issue(0, 1, 0, 32'h3, 32'h0, 32'h0, 1, 1, 0, 0, 1);
      issue(0, 3, 0, 32'h0, 32'h0, 32'h0, 1, 1, 0, 0, 1);
      issue(0, 2, 0, 32'h200, 32'h0, 32'h0, 1, 1, 0, 0, 1);
      issue(1, 0, 0, 32'h200, 32'hFF, 32'h0, 1, 1, 0, 0, 1);

      // Highest legal word index 127.
      issue(1, 2, 0, 32'h1FC, 32'h1234_5678, 32'h0, 0, 2, 0, 1, 1);
      issue(0, 0, 1, 32'h1FF, 32'h0, 32'h0000_0078, 0, 2, 1, 0, 1);
      issue(1, 1, 0, 32'h1FE, 32'hAAAA_80F0, 32'h0, 0, 3, 1, 1, 1);
      issue(0, 1, 1, 32'h1FE, 32'h0, 32'hFFFF_80F0, 0, 2, 1, 0, 1);
      issue(0, 0, 1, 32'h1FF, 32'h0, 32'hFFFF_FFF0, 0, 2, 1, 0, 1);
      issue(0, 0, 0, 32'h1FC, 32'h0, 32'h0000_0012, 0, 2, 1, 0, 1);
      drain();
      chk("mem127_after_sh", mem[127], 32'h1234_80F0);

      // Back-to-back with req_valid held across three requests.
      issue(0, 2, 0, 32'h8, 32'h0, 32'hDE11_BEEF, 0, 2, 1, 0, 1);
      issue(0, 0, 0, 32'hB, 32'h0, 32'h0000_00EF, 0, 2, 1, 0, 1);
      issue(0, 3, 0, 32'h8, 32'h0, 32'h0, 1, 1, 0, 0, 1);
      drain();

      // Reset during the WRITE of a byte store: nothing commits, no response.
      issue(1, 0, 0, 32'h8, 32'h0000_0055, 32'h0, 0, 0, 0, 0, 0);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("write_en_before_rst", 32'(mem_write_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("write_en_gated", 32'(mem_write_en), 32'd0);
      @(posedge clk);
      #1;
      chk("ready_in_rst", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_mid_rst", 32'(req_ready), 32'd1);
      chk("mem2_after_rst", mem[2], 32'hDE11_BEEF);
      repeat (3) @(posedge clk);
      #1;

      // Unit still works after the aborted request.
      issue(0, 0, 0, 32'h8, 32'h0, 32'h0000_00DE, 0, 2, 1, 0, 1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, expected completion");
      $fatal(1, "timeout");
   end

endmodule
